// File: rtl/boss_pkg.sv
// Shared constants and types for the boss motion / shot datapath.
package boss_pkg;

  localparam logic [9:0] X_MIN    = 10'd64;
  localparam logic [9:0] X_MAX    = 10'd512;
  localparam logic [9:0] X_HOME   = 10'd288;
  localparam logic [9:0] X_STEP   = 10'd2;
  localparam logic [9:0] Y_TOP    = 10'd32;
  localparam logic [9:0] Y_BOTTOM = 10'd320;
  localparam logic [9:0] Y_STEP   = 10'd4;
  localparam logic [9:0] BOSS_W   = 10'd64;
  localparam logic [9:0] BOSS_H   = 10'd48;

  localparam logic [7:0] BASE_HP      = 8'd16;
  localparam logic [7:0] HP_PER_LEVEL = 8'd8;

  typedef enum logic [1:0] {DIR_SW, DIR_S, DIR_SE, DIR_AIM} shot_dir_e;
  typedef enum logic {SH_IDLE, SH_EMIT} shot_state_e;

  function automatic logic [7:0] hp_init_f(input logic [2:0] difficulty);
    return BASE_HP + {5'd0, difficulty} * HP_PER_LEVEL;
  endfunction

endpackage

// File: rtl/boss_shot_if.sv
// Valid/ready link carrying one boss shot to the projectile pool.
interface boss_shot_if;
  import boss_pkg::*;

  logic      shot_valid;
  logic      shot_ready;
  logic [9:0] shot_x;
  logic [9:0] shot_y;
  shot_dir_e shot_dir;

  modport master (output shot_valid, shot_x, shot_y, shot_dir, input shot_ready);
  modport slave  (input shot_valid, shot_x, shot_y, shot_dir, output shot_ready);

endinterface

// File: rtl/boss_shot_seq.sv
// Burst sequencer: turns one trigger into four shots (SW, S, SE, aimed) from a latched origin.
module boss_shot_seq
  import boss_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       trigger,
  input  logic       enable,
  input  logic [9:0] origin_x,
  input  logic [9:0] origin_y,
  boss_shot_if.master shot
);

  shot_state_e state_q, state_d;
  logic [1:0]  idx_q;
  logic [9:0]  ox_q, oy_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) state_q <= SH_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      idx_q <= 2'd0;
      ox_q  <= 10'd0;
      oy_q  <= 10'd0;
    end else if (state_q == SH_IDLE && trigger && enable) begin
      idx_q <= 2'd0;
      ox_q  <= origin_x;
      oy_q  <= origin_y;
    end else if (state_q == SH_EMIT && enable && shot.shot_ready) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Losing the boss aborts the burst even with a beat outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SH_IDLE: if (trigger && enable) state_d = SH_EMIT;
      SH_EMIT: begin
        if (!enable)                              state_d = SH_IDLE;
        else if (shot.shot_ready && idx_q == 2'd3) state_d = SH_IDLE;
      end
      default: state_d = SH_IDLE;
    endcase
  end

  always_comb begin
    shot.shot_valid = (state_q == SH_EMIT);
    shot.shot_x     = ox_q;
    shot.shot_y     = oy_q;
    shot.shot_dir   = shot_dir_e'(idx_q);
  end

endmodule

// File: rtl/boss_motion.sv
// Boss sprite motion, HP / defeat tracking and shot burst launch.
// Macro BOSS_ENRAGE_EN: doubles the sweep step while HP is at or below a quarter of its start value.
module boss_motion
  import boss_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [2:0] difficulty,
  input  logic       Boss_exists,
  input  logic       boss_hold,
  input  logic       boss_back_and_forth,
  input  logic       boss_flydown,
  input  logic       boss_rise,
  input  logic       boss_shoot1,
  input  logic       boss_shoot2,
  input  logic       boss_shoot3,
  input  logic       boss_shoot4,
  input  logic       player_hit,
  output logic [9:0] BossX,
  output logic [9:0] BossY,
  output logic       hit_top,
  output logic       hit_bottom,
  output logic       beat_Boss,
  output logic [7:0] boss_hp,
  boss_shot_if.master shot
);

  logic [9:0] x_q, y_q, x_d, y_d, step;
  logic       right_q, right_d;
  logic [7:0] hp_q, hp_init;
  logic       beat_q;

  assign hp_init = hp_init_f(difficulty);

`ifdef BOSS_ENRAGE_EN
  assign step = (Boss_exists && hp_q <= {2'b00, hp_init[7:2]}) ? (X_STEP << 1) : X_STEP;
`else
  assign step = X_STEP;
`endif

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    right_d = right_q;
    if (!Boss_exists) begin
      x_d     = X_HOME;
      y_d     = Y_TOP;
      right_d = 1'b1;
    end else if (boss_flydown) begin
      y_d = (y_q + Y_STEP >= Y_BOTTOM) ? Y_BOTTOM : y_q + Y_STEP;
    end else if (boss_rise) begin
      y_d = (y_q <= Y_TOP + Y_STEP) ? Y_TOP : y_q - Y_STEP;
    end else if (boss_back_and_forth) begin
      // Reaching a limit flips direction on the same frame.
      if (right_q) begin
        if (x_q + step >= X_MAX) begin
          x_d     = X_MAX;
          right_d = 1'b0;
        end else begin
          x_d = x_q + step;
        end
      end else begin
        if (x_q <= X_MIN + step) begin
          x_d     = X_MIN;
          right_d = 1'b1;
        end else begin
          x_d = x_q - step;
        end
      end
    end else if (boss_hold) begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      x_q     <= X_HOME;
      y_q     <= Y_TOP;
      right_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      right_q <= right_d;
    end
  end

  // A defeated boss keeps HP at zero until Reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      hp_q   <= 8'd0;
      beat_q <= 1'b0;
    end else if (!Boss_exists) begin
      if (!beat_q) hp_q <= hp_init;
    end else if (player_hit && hp_q != 8'd0) begin
      hp_q <= hp_q - 8'd1;
      if (hp_q == 8'd1) beat_q <= 1'b1;
    end
  end

  assign BossX      = x_q;
  assign BossY      = y_q;
  assign hit_top    = (y_q == Y_TOP);
  assign hit_bottom = (y_q == Y_BOTTOM);
  assign boss_hp    = hp_q;
  assign beat_Boss  = beat_q;

  boss_shot_seq u_shot_seq (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .trigger   (boss_shoot1 | boss_shoot2 | boss_shoot3 | boss_shoot4),
    .enable    (Boss_exists & ~beat_q),
    .origin_x  (x_q + (BOSS_W >> 1)),
    .origin_y  (y_q + BOSS_H),
    .shot      (shot)
  );

endmodule

// File: tb/tb_boss_motion.sv
// Self-checking bench for boss_motion: directed scenarios plus randomized frames against a behavioural model.
module tb_boss_motion;

  logic       frame_clk;
  logic       Reset;
  logic [2:0] difficulty;
  logic       Boss_exists, boss_hold, boss_back_and_forth, boss_flydown, boss_rise;
  logic       boss_shoot1, boss_shoot2, boss_shoot3, boss_shoot4, player_hit;
  logic [9:0] BossX, BossY;
  logic       hit_top, hit_bottom, beat_Boss;
  logic [7:0] boss_hp;

  boss_shot_if sif ();

  boss_motion dut (
    .frame_clk           (frame_clk),
    .Reset               (Reset),
    .difficulty          (difficulty),
    .Boss_exists         (Boss_exists),
    .boss_hold           (boss_hold),
    .boss_back_and_forth (boss_back_and_forth),
    .boss_flydown        (boss_flydown),
    .boss_rise           (boss_rise),
    .boss_shoot1         (boss_shoot1),
    .boss_shoot2         (boss_shoot2),
    .boss_shoot3         (boss_shoot3),
    .boss_shoot4         (boss_shoot4),
    .player_hit          (player_hit),
    .BossX               (BossX),
    .BossY               (BossY),
    .hit_top             (hit_top),
    .hit_bottom          (hit_bottom),
    .beat_Boss           (beat_Boss),
    .boss_hp             (boss_hp),
    .shot                (sif)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position, direction, HP, defeat flag and a queue of pending shots.
  typedef struct {int x; int y; int d;} shot_t;
  shot_t sq[$];
  int mx, my, mhp, hpi, stp, ox, oy;
  bit mright, mbeat, men;
  shot_t s;

  always @(posedge frame_clk) begin
    if (Reset) begin
      mx = 288; my = 32; mright = 1; mhp = 0; mbeat = 0;
      sq.delete();
    end else begin
      ox  = mx;
      oy  = my;
      hpi = 16 + 8 * int'(difficulty);
      men = Boss_exists && !mbeat;
      if (sq.size() > 0) begin
        if (!men) sq.delete();
        else if (sif.shot_ready) void'(sq.pop_front());
      end else if ((boss_shoot1 || boss_shoot2 || boss_shoot3 || boss_shoot4) && men) begin
        for (int k = 0; k < 4; k++) begin
          s.x = ox + 32; s.y = oy + 48; s.d = k;
          sq.push_back(s);
        end
      end
      stp = 2;
`ifdef BOSS_ENRAGE_EN
      if (Boss_exists && mhp <= hpi / 4) stp = 4;
`endif
      if (!Boss_exists) begin
        mx = 288; my = 32; mright = 1;
      end else if (boss_flydown) begin
        my = (my + 4 > 320) ? 320 : my + 4;
      end else if (boss_rise) begin
        my = (my - 4 < 32) ? 32 : my - 4;
      end else if (boss_back_and_forth) begin
        if (mright) begin
          mx = mx + stp;
          if (mx >= 512) begin mx = 512; mright = 0; end
        end else begin
          mx = mx - stp;
          if (mx <= 64) begin mx = 64; mright = 1; end
        end
      end
      if (!Boss_exists) begin
        if (!mbeat) mhp = hpi;
      end else if (player_hit && mhp > 0) begin
        mhp = mhp - 1;
        if (mhp == 0) mbeat = 1;
      end
    end
  end

  always @(negedge frame_clk) begin
    if (chk_en) begin
      chk("BossX", int'(BossX), mx);
      chk("BossY", int'(BossY), my);
      chk("hit_top", int'(hit_top), int'(my == 32));
      chk("hit_bottom", int'(hit_bottom), int'(my == 320));
      chk("boss_hp", int'(boss_hp), mhp);
      chk("beat_Boss", int'(beat_Boss), int'(mbeat));
      chk("shot_valid", int'(sif.shot_valid), int'(sq.size() > 0));
      if (sq.size() > 0) begin
        chk("shot_x", int'(sif.shot_x), sq[0].x);
        chk("shot_y", int'(sif.shot_y), sq[0].y);
        chk("shot_dir", int'(sif.shot_dir), sq[0].d);
      end
    end
  end

  task automatic next(input int n);
    repeat (n) begin
      @(negedge frame_clk);
      #1;
    end
  endtask

  task automatic idle_cmds();
    boss_hold = 0; boss_back_and_forth = 0; boss_flydown = 0; boss_rise = 0;
    boss_shoot1 = 0; boss_shoot2 = 0; boss_shoot3 = 0; boss_shoot4 = 0; player_hit = 0;
  endtask

  task automatic do_reset();
    Reset = 1; next(1); Reset = 0;
  endtask

  int maxx, oob;

  initial begin
    Reset = 1; difficulty = 0; Boss_exists = 0; sif.shot_ready = 0;
    idle_cmds();
    next(1);
    chk_en = 1;
    next(1);
    chk("rst_x", int'(BossX), 288);
    chk("rst_y", int'(BossY), 32);
    chk("rst_hp", int'(boss_hp), 0);
    chk("rst_beat", int'(beat_Boss), 0);
    chk("rst_valid", int'(sif.shot_valid), 0);
    Reset = 0;

    // Sweep
    difficulty = 2; Boss_exists = 0; next(1);
    chk("hp_load", int'(boss_hp), 32);
    Boss_exists = 1; boss_back_and_forth = 1;
    maxx = 0; oob = 0;
    for (int i = 0; i < 300; i++) begin
      next(1);
      if (int'(BossX) > maxx) maxx = int'(BossX);
      if (BossX < 10'd64 || BossX > 10'd512) oob++;
    end
    chk("sweep_max", maxx, 512);
    chk("sweep_oob", oob, 0);
    chk("sweep_x", int'(BossX), 136);
    chk("sweep_y", int'(BossY), 32);
    chk("sweep_top", int'(hit_top), 1);
    next(18);
    chk("sweep_x100", int'(BossX), 100);
    boss_back_and_forth = 0;

    // Dive and rise
    boss_flydown = 1; next(71);
    chk("dive_71", int'(hit_bottom), 0);
    next(1);
    chk("dive_72", int'(hit_bottom), 1);
    chk("dive_y", int'(BossY), 320);
    boss_flydown = 0; boss_rise = 1; next(71);
    chk("rise_71", int'(hit_top), 0);
    next(1);
    chk("rise_72", int'(hit_top), 1);
    boss_rise = 0; boss_hold = 1;

    // Full burst with ready held high
    sif.shot_ready = 1; boss_shoot1 = 1; next(1); boss_shoot1 = 0;
    for (int k = 0; k < 4; k++) begin
      chk("burst_valid", int'(sif.shot_valid), 1);
      chk("burst_dir", int'(sif.shot_dir), k);
      chk("burst_x", int'(sif.shot_x), 132);
      chk("burst_y", int'(sif.shot_y), 80);
      next(1);
    end
    chk("burst_end", int'(sif.shot_valid), 0);

    // Back-pressure with an ignored retrigger
    boss_shoot2 = 1; next(1); boss_shoot2 = 0;
    next(1);
    sif.shot_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) boss_shoot3 = 1;
      next(1);
      boss_shoot3 = 0;
    end
    chk("stall_dir", int'(sif.shot_dir), 1);
    chk("stall_x", int'(sif.shot_x), 132);
    sif.shot_ready = 1; next(3);
    chk("stall_end", int'(sif.shot_valid), 0);
    next(2);
    chk("no_queue", int'(sif.shot_valid), 0);

    // Abort on boss loss
    sif.shot_ready = 0; boss_shoot4 = 1; next(1); boss_shoot4 = 0;
    next(2);
    Boss_exists = 0; next(1);
    chk("abort_valid", int'(sif.shot_valid), 0);
    chk("abort_x", int'(BossX), 288);
    chk("abort_y", int'(BossY), 32);
    Boss_exists = 1; boss_hold = 0;

    // Low-HP sweep step
    do_reset();
    difficulty = 0; Boss_exists = 0; next(1);
    chk("enr_hp16", int'(boss_hp), 16);
    Boss_exists = 1;
    repeat (12) begin player_hit = 1; next(1); player_hit = 0; next(1); end
    chk("enr_hp4", int'(boss_hp), 4);
    boss_back_and_forth = 1; next(1); boss_back_and_forth = 0;
`ifdef BOSS_ENRAGE_EN
    chk("enr_step", int'(BossX), 292);
`else
    chk("enr_step", int'(BossX), 290);
`endif

    // Defeat
    do_reset();
    difficulty = 2; Boss_exists = 0; next(1);
    Boss_exists = 1;
    repeat (31) begin player_hit = 1; next(1); player_hit = 0; next(1); end
    chk("hp_31", int'(boss_hp), 1);
    chk("beat_31", int'(beat_Boss), 0);
    player_hit = 1; next(1); player_hit = 0;
    chk("hp_32", int'(boss_hp), 0);
    chk("beat_32", int'(beat_Boss), 1);
    repeat (3) begin player_hit = 1; next(1); player_hit = 0; next(1); end
    chk("hp_extra", int'(boss_hp), 0);
    Boss_exists = 0; next(2);
    chk("beat_sticky", int'(beat_Boss), 1);
    chk("hp_sticky", int'(boss_hp), 0);
    Boss_exists = 1; sif.shot_ready = 1; boss_shoot1 = 1; next(1); boss_shoot1 = 0;
    chk("beat_noshot", int'(sif.shot_valid), 0);

    // Randomized frames
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      Reset               = ($urandom_range(0, 599) == 0);
      Boss_exists         = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 99) == 0) difficulty = 3'($urandom_range(0, 7));
      boss_flydown        = ($urandom_range(0, 5) == 0);
      boss_rise           = ($urandom_range(0, 5) == 0);
      boss_back_and_forth = ($urandom_range(0, 2) != 0);
      boss_hold           = ($urandom_range(0, 3) == 0);
      boss_shoot1         = ($urandom_range(0, 15) == 0);
      boss_shoot2         = ($urandom_range(0, 31) == 0);
      boss_shoot3         = ($urandom_range(0, 31) == 0);
      boss_shoot4         = ($urandom_range(0, 31) == 0);
      player_hit          = ($urandom_range(0, 7) == 0);
      sif.shot_ready      = ($urandom_range(0, 1) == 1);
      next(1);
    end
    Reset = 0; idle_cmds();
    next(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
